uart_tx_8n1: RTL and testbench
==============================

Name: uart_tx_8n1

Overview:
Transmit-only asynchronous serial port that sends one 8-bit byte per request as a standard 8N1 frame on a single output line. The bit period is a fixed number of system clocks set by parameter. It is used as a host-side stimulus source feeding the SoC `rx` pin, and as the UART TX block inside the SoC. It has no FIFO; flow control is the `busy` output.

Parameters:
- CLOCK_DIV, default 8: system clocks per serial bit; legal range 2..2^CLOCK_COUNTER_BITS.
- CLOCK_COUNTER_BITS, default 4: width of the bit-period counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- data  in  8  byte to send; sampled only at frame start.
- send  in  1  start request, level-sampled while idle.
- tx  out  1  serial line; idles high; registered output.
- busy  out  1  high while a frame is in progress; registered output.

Behaviour:
- Reset: while nreset=0, tx=1, busy=0, state=IDLE, and all counters clear. Reset is asynchronous, so it takes effect immediately, including mid-frame with no partial-frame completion.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: tx=1, busy=0. On the rising edge where send=1:
  - data is latched into the shift register;
  - state moves to START;
  - tx drives 0 and busy drives 1 from that same edge.
- START: tx=0 for exactly CLOCK_DIV clocks.
- DATA: 8 bits, LSB first, each held for exactly CLOCK_DIV clocks. The bit index counts 0..7.
- STOP: tx=1 for CLOCK_DIV clocks. At the end of STOP, busy returns to 0 and the block enters IDLE.
- Frame timing: busy is high for exactly 10*CLOCK_DIV clocks; with default parameters that is 80 clocks.
- Bit-period counter: counts 0..CLOCK_DIV-1 and wraps. State and bit advance occur on the wrap.
- send while busy=1 is ignored; no queuing.
- data changes during a frame have no effect on the frame.
- send still high when the block returns to IDLE starts a new frame on that edge (back-to-back frames, no extra idle time). Callers that want one byte must drop send within 10*CLOCK_DIV clocks.
- No glitches on tx: tx is driven directly from a flop.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent for CLOCK_DIV clocks between bit 7 and STOP. Frame length becomes 11*CLOCK_DIV clocks, and busy is extended to match.
- Undefined: plain 8N1 as above, with no parity logic synthesized.

Test Plan:
- Reset and idle: nreset=0 for 50 clocks, then release with send=0 -> tx=1 and busy=0 throughout; no activity for 200 clocks.
- Single byte, defaults (CLOCK_DIV=8): data=0x5A, send high for 2 clocks -> tx sequence 0,0,1,0,1,1,0,1,0,1 (start, bits LSB-first, stop), each bit exactly 8 clocks; busy high for exactly 80 clocks; no second frame.
- Second byte after idle: data=0xA5 sent about 100 clocks after the first request -> tx bits 0,1,0,1,0,0,1,0,1,1; busy high for 80 clocks.
- Data and send during busy: start 0x5A, then change data to 0xFF at clock 20 and pulse send at clock 30 -> transmitted frame is still 0x5A; no extra frame follows.
- Async reset mid-frame: assert nreset during bit 3 -> tx=1 and busy=0 before the next clock edge. After release, a new send of 0x3C produces a complete correct frame.
- Back-to-back and parity: hold send=1 continuously with data=0x5A -> consecutive frames with stop bit followed directly by the next start bit, and busy drops for 0 cycles between them in IDLE. With UART_TX_PARITY_EN defined, 0x5A yields parity bit 0 and 0x01 yields parity bit 1; frame length is 88 clocks.

Source files
------------

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: transmit-only serial port sending one byte per request as an
// 8N1 frame (start bit, 8 data bits LSB first, stop bit), CLOCK_DIV system
// clocks per bit. There is no FIFO; the busy output provides flow control.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// (XOR of the 8 data bits) between data bit 7 and the stop bit. This stretches
// each frame to 11 bit periods. In the default build no parity logic exists.
//
// tx and busy come straight from flops, so the line cannot glitch. If send is
// still high when a stop bit ends, the next start bit follows on that same
// edge and busy stays high throughout.
module uart_tx_8n1 #(
    parameter int CLOCK_DIV          = 8,
    parameter int CLOCK_COUNTER_BITS = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // Last count of a bit period; the counter wraps here and the FSM advances.
    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);

    state_t                        state_q, state_d;
    logic [CLOCK_COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]                    bit_q, bit_d;
    logic [7:0]                    shift_q, shift_d;
    logic                          tx_q, tx_d;
    logic                          busy_q, busy_d;
    logic                          wrap;
`ifdef UART_TX_PARITY_EN
    logic                          parity_q, parity_d;
`endif

    assign wrap = (cnt_q == CNT_LAST);
    assign tx   = tx_q;
    assign busy = busy_q;

    // State, counters, shift register and output flops; reset drops the frame at once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: tx_d/busy_d describe the line level for the coming state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == ST_IDLE || wrap) ? '0 : cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                bit_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    shift_d  = data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            ST_START: begin
                if (wrap) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            ST_DATA: begin
                if (wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (wrap) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (wrap) begin
                    if (send) begin
                        // Back-to-back: next start bit directly after the stop bit.
                        shift_d  = data;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^data;
`endif
                        state_d  = ST_START;
                        tx_d     = 1'b0;
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        tx_d     = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Testbench for uart_tx_8n1. The driver pushes each accepted byte into a
// queue. A separate monitor collects every frame from the tx line and compares
// it with the frame built from that byte by the reference model.
module tb_uart_tx_8n1;
    localparam int CD  = 8;
    localparam int CCB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CLKS = NB * CD;

    logic       clk    = 1'b0;
    logic       nreset = 1'b0;
    logic       send   = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       tx;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    bit         in_frame = 1'b0;

    uart_tx_8n1 #(.CLOCK_DIV(CD), .CLOCK_COUNTER_BITS(CCB)) dut (
        .clk   (clk),
        .nreset(nreset),
        .data  (data),
        .send  (send),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference frame: index 0 is the first bit on the wire.
    function automatic logic [NB-1:0] model_frame(input logic [7:0] d);
        logic [NB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int j = 0; j < 8; j++) f[1+j] = d[j];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, collects one frame per busy period.
    initial begin : monitor
        logic [NB-1:0] obs;
        logic [NB-1:0] expf;
        logic [7:0]    expd;
        bit            have_exp;
        bit            hold_ok;
        int            idx;
        obs = '1; expf = '1; expd = '0; have_exp = 1'b0; hold_ok = 1'b1; idx = 0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                in_frame = 1'b0;
            end else if (in_frame) begin
                if (busy !== 1'b1) begin
                    check("busy_len", idx, FRAME_CLKS);
                    in_frame = 1'b0;
                end else begin
                    if (idx % CD == 0) obs[idx/CD] = tx;
                    else if (tx !== obs[idx/CD]) hold_ok = 1'b0;
                    idx++;
                    if (idx == FRAME_CLKS) begin
                        in_frame = 1'b0;
                        $display("frame data=%02h tx_bits(last..first)=%b", expd, obs);
                        if (have_exp) check("frame_bits", obs, expf);
                        check("bit_hold", hold_ok, 1);
                    end
                end
            end else if (busy === 1'b1) begin
                have_exp = (exp_q.size() != 0);
                check("frame_expected", have_exp, 1);
                if (have_exp) begin
                    expd = exp_q.pop_front();
                    expf = model_frame(expd);
                end
                in_frame = 1'b1;
                obs      = '1;
                obs[0]   = tx;
                hold_ok  = 1'b1;
                idx      = 1;
            end else begin
                check("idle_tx", tx, 1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1) check("busy_timeout", busy, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold);
        @(negedge clk);
        wait_idle();
        data = d;
        send = 1'b1;
        exp_q.push_back(d);
        repeat (hold) @(negedge clk);
        send = 1'b0;
    endtask

    initial begin : driver
        int cnt;
        int n;
        // Reset and idle
        nreset = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        @(negedge clk);
        #2 nreset = 1'b1;
        repeat (200) @(negedge clk);

        // Single byte, then a second byte about 100 clocks after the first request
        send_byte(8'h5A, 2);
        repeat (98) @(negedge clk);
        send_byte(8'hA5, 2);

        // data and send changes during a frame must not affect it
        send_byte(8'h5A, 1);
        repeat (19) @(negedge clk);
        data = 8'hFF;
        repeat (10) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;

        // Asynchronous reset during data bit 3
        @(negedge clk);
        wait_idle();
        data = 8'hC3;
        send = 1'b1;
        exp_q.push_back(8'hC3);
        wait_busy();
        send = 1'b0;
        repeat (35) @(posedge clk);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        #2 nreset = 1'b1;
        send_byte(8'h3C, 2);

        // Back-to-back frames with send held high
        @(negedge clk);
        wait_idle();
        data = 8'h5A;
        send = 1'b1;
        repeat (3) exp_q.push_back(8'h5A);
        wait_busy();
        cnt = 0;
        while (busy === 1'b1 && cnt < 4 * FRAME_CLKS) begin
            cnt++;
            if (cnt == 2 * FRAME_CLKS + 10) send = 1'b0;
            @(negedge clk);
        end
        send = 1'b0;
        check("b2b_busy_len", cnt, 3 * FRAME_CLKS);

        // Parity-relevant directed byte
        send_byte(8'h01, 2);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            send_byte(8'($urandom_range(0, 255)), $urandom_range(1, FRAME_CLKS - 1));
            if ($urandom_range(0, 1) == 1) data = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end

        // Drain outstanding frames
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 8 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
